// File: rtl/dreg_pkg.sv
// Shared definitions for the D-register pipeline.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package dreg_pkg;

    // Value every data register takes while the asynchronous reset is asserted.
    localparam int unsigned DREG_RST_DATA = 0;

    // Bits needed to hold an occupancy count from 0 up to and including 'stages'.
    function automatic int count_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage : dreg_pkg

// File: rtl/dreg_stage.sv
// One valid/data register slot of the pipeline, loaded when its move enable is high.
// Latency: one clock from upstream source to this slot.
// Backpressure: holds its contents while mv_i is low; the move chain upstream decides stalls.
module dreg_stage
    import dreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             sclr,
    input  logic             mv_i,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;

    // Next state: flush only drops validity; data is captured only from a valid
    // upstream word so an invalid slot never toggles its data bits.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (sclr) begin
            vld_d = 1'b0;
        end else if (mv_i) begin
            vld_d = up_vld_i;
            if (up_vld_i) begin
                dat_d = up_dat_i;
            end
        end
    end

    // Slot registers with immediate clear on reset.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            vld_q <= 1'b0;
            dat_q <= WIDTH'(DREG_RST_DATA);
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule : dreg_stage

// File: rtl/dreg_pipeline.sv
// Chain of STAGES valid/ready register slots with bubble collapse, flush and occupancy count.
// Latency: STAGES-1 clocks after the accepting edge with no stall (STAGES=1: visible right after it).
// Backpressure: in_ready is combinational from out_ready; it drops only when every slot is full and out_ready is low.
module dreg_pipeline
    import dreg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CW     = count_width(STAGES)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             sclr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [STAGES-1:0] stg_vld;
    logic [WIDTH-1:0]  stg_dat [STAGES];
    logic [STAGES-1:0] stg_mv;

    logic              in_fire;
    logic              out_fire;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Move enables, resolved from the output side back to the input: a slot may
    // load when it is empty or when the slot after it is itself moving.
    always_comb begin
        logic chain;
        stg_mv = '0;
        chain  = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain     = !stg_vld[i] | chain;
            stg_mv[i] = chain;
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            logic             up_vld;
            logic [WIDTH-1:0] up_dat;

            if (g == 0) begin : g_src_in
                assign up_vld = in_valid;
                assign up_dat = in_data;
            end else begin : g_src_prev
                assign up_vld = stg_vld[g-1];
                assign up_dat = stg_dat[g-1];
            end

            dreg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .areset   (areset),
                .sclr     (sclr),
                .mv_i     (stg_mv[g]),
                .up_vld_i (up_vld),
                .up_dat_i (up_dat),
                .vld_o    (stg_vld[g]),
                .dat_o    (stg_dat[g])
            );
        end
    endgenerate

    assign in_ready  = stg_mv[0];
    assign out_valid = stg_vld[STAGES-1];
    assign out_data  = stg_dat[STAGES-1];

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Occupancy tracks handshakes rather than summing valid bits, so count stays
    // a plain register output with no path from in_valid; flush empties it.
    always_comb begin
        count_d = count_q;
        if (sclr) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register, cleared immediately on reset.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : dreg_pipeline
